// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tone_gen
// Description : Square-wave tone generator for the speaker pin. Converts a
//               requested frequency in Hz into a half-period cycle count with
//               a 32-step restoring shift-subtract divider, then drives a
//               toggle counter. New pitches are applied only at waveform edges
//               so that no runt pulses are produced.
// Ports       : FPGA_CLK1_50     - system clock
//               reset            - asynchronous active-high reset
//               desiredFrequency - requested tone in Hz (0 = rest)
//               play             - 1 = speaker enabled, 0 = muted
//               spkr             - square-wave output
//               busy             - division in progress
//               active           - valid half-period loaded and play=1
//               half_period      - committed half-period in cycles (0 = silent)
// Revision    : 1.0 - initial release
// ============================================================================
module tone_gen #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned MIN_HZ = 20,
    parameter int unsigned MAX_HZ = 20_000
) (
    input  logic        FPGA_CLK1_50,
    input  logic        reset,
    input  logic [31:0] desiredFrequency,
    input  logic        play,
    output logic        spkr,
    output logic        busy,
    output logic        active,
    output logic [31:0] half_period
);

    localparam logic [31:0] C_DIVIDEND = CLK_HZ;
    localparam logic [31:0] C_MIN_HZ   = MIN_HZ;
    localparam logic [31:0] C_MAX_HZ   = MAX_HZ;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIV    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_f_cur;
    logic [32:0] r_divisor;
    logic [32:0] r_rem;
    logic [31:0] r_quot;
    logic [4:0]  r_iter;
    logic [31:0] r_pending;
    logic        r_pending_vld;
    logic [31:0] r_half_period;
    logic [31:0] r_cnt;
    logic        r_spkr;
    logic        r_busy;
    logic        r_active;

    logic        w_in_range;
    logic [33:0] w_rem_sh;
    logic        w_sub_ok;
    logic [32:0] w_rem_diff;
    logic [32:0] w_rem_next;
    logic        w_wrap;

    assign w_in_range = (desiredFrequency != 32'd0) &&
                        (desiredFrequency >= C_MIN_HZ) &&
                        (desiredFrequency <= C_MAX_HZ);

    // Restoring division step: the dividend sits in the quotient register and
    // is shifted out of its MSB into the partial remainder, while quotient
    // bits are shifted in at the LSB.
    assign w_rem_sh   = {r_rem, r_quot[31]};
    assign w_sub_ok   = (w_rem_sh >= {1'b0, r_divisor});
    // When the subtraction is taken the result is below the divisor and so
    // fits in 33 bits; modular subtraction on the low bits is exact.
    assign w_rem_diff = w_rem_sh[32:0] - r_divisor;
    assign w_rem_next = w_sub_ok ? w_rem_diff : w_rem_sh[32:0];

    assign w_wrap = (r_cnt == (r_half_period - 32'd1));

    always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_f_cur       <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_quot        <= '0;
            r_iter        <= '0;
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
            r_half_period <= '0;
            r_cnt         <= '0;
            r_spkr        <= 1'b0;
            r_busy        <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_active <= play && (r_half_period != 32'd0);

            // Toggle engine. A pending pitch is swapped in only on a wrap, so
            // the current half-period always completes at its old length.
            if ((r_half_period == 32'd0) || !play) begin
                r_spkr <= 1'b0;
                r_cnt  <= '0;
            end else if (w_wrap) begin
                r_spkr <= ~r_spkr;
                r_cnt  <= '0;
                if (r_pending_vld) begin
                    r_half_period <= r_pending;
                    r_pending_vld <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            // Frequency tracking / divider control. Assignments here come
            // after the toggle engine so they take priority on collisions.
            case (r_state)
                S_IDLE: begin
                    if (desiredFrequency != r_f_cur) begin
                        r_f_cur <= desiredFrequency;
                        if (!w_in_range) begin
                            r_half_period <= '0;
                            r_pending_vld <= 1'b0;
                            r_spkr        <= 1'b0;
                            r_cnt         <= '0;
                        end else begin
                            r_divisor <= {desiredFrequency, 1'b0};
                            r_rem     <= '0;
                            r_quot    <= C_DIVIDEND;
                            r_iter    <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[30:0], w_sub_ok};
                    r_iter <= r_iter + 5'd1;
                    if (r_iter == 5'd31) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_half_period == 32'd0) begin
                        // Starting from silence: no edge to wait for.
                        r_half_period <= r_quot;
                        r_pending_vld <= 1'b0;
                        r_cnt         <= '0;
                        r_spkr        <= 1'b0;
                    end else begin
                        r_pending     <= r_quot;
                        r_pending_vld <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign spkr        = r_spkr;
    assign busy        = r_busy;
    assign active      = r_active;
    assign half_period = r_half_period;

endmodule
`default_nettype wire

// File: tb/tb_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_gen
// Description : Self-checking testbench for tone_gen. Table of reference
//               frequencies, randomized frequencies against an arithmetic
//               model, and hand-written sequences for edge-aligned pitch
//               changes, muting, out-of-range silence and reset mid-division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_gen;

    localparam longint C_CLK_HZ = 50_000_000;
    localparam longint C_MIN_HZ = 20;
    localparam longint C_MAX_HZ = 20_000;
    localparam int     C_WAIT_LIMIT = 20000;

    logic        clk;
    logic        reset;
    logic [31:0] desiredFrequency;
    logic        play;
    logic        spkr;
    logic        busy;
    logic        active;
    logic [31:0] half_period;

    int n_pass  = 0;
    int n_total = 0;

    tone_gen dut (
        .FPGA_CLK1_50     (clk),
        .reset            (reset),
        .desiredFrequency (desiredFrequency),
        .play             (play),
        .spkr             (spkr),
        .busy             (busy),
        .active           (active),
        .half_period      (half_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] freq;
        logic [31:0] exp_hp;
        int          exp_busy;
    } vec_t;

    // Reference model: half-period in cycles for a requested frequency.
    function automatic logic [31:0] model_hp(input logic [31:0] f);
        longint lf;
        lf = longint'(f);
        if (lf == 0 || lf < C_MIN_HZ || lf > C_MAX_HZ) return 32'd0;
        return 32'(C_CLK_HZ / (2 * lf));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a frequency and run 34 cycles, counting busy cycles.
    task automatic run_div(input logic [31:0] f, output int bc);
        desiredFrequency = f;
        bc = 0;
        repeat (34) begin
            tick();
            if (busy) bc++;
        end
    endtask

    task automatic go_silent();
        desiredFrequency = 32'd0;
        repeat (2) tick();
    endtask

    // Cycles until spkr changes; returns the limit on timeout.
    task automatic wait_toggle(output int cycles);
        logic prev;
        prev = spkr;
        cycles = 0;
        while (spkr == prev && cycles < C_WAIT_LIMIT) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[10];
        int          bc;
        int          cyc;
        logic [31:0] f;

        vecs[0] = '{32'd440,   32'd56818,   33};
        vecs[1] = '{32'd261,   32'd95785,   33};
        vecs[2] = '{32'd20000, 32'd1250,    33};
        vecs[3] = '{32'd20,    32'd1250000, 33};
        vecs[4] = '{32'd1000,  32'd25000,   33};
        vecs[5] = '{32'd0,     32'd0,       0};
        vecs[6] = '{32'd25000, 32'd0,       0};
        vecs[7] = '{32'd10,    32'd0,       0};
        vecs[8] = '{32'd19,    32'd0,       0};
        vecs[9] = '{32'd20001, 32'd0,       0};

        // Reset state
        reset = 1'b1;
        play = 1'b0;
        desiredFrequency = 32'd0;
        repeat (3) tick();
        chk("reset_spkr", spkr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_active", active, 0);
        chk("reset_hp", half_period, 0);
        reset = 1'b0;
        play = 1'b1;
        tick();

        // Table-driven reference quotients and silence cases
        for (int i = 0; i < 10; i++) begin
            go_silent();
            run_div(vecs[i].freq, bc);
            chk($sformatf("tbl_hp_%0d", vecs[i].freq), half_period, vecs[i].exp_hp);
            chk($sformatf("tbl_busy_%0d", vecs[i].freq), bc, vecs[i].exp_busy);
        end

        // Randomized frequencies against the model
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       f = $urandom_range(20, 20000);
                1:       f = $urandom_range(20001, 100000);
                2:       f = $urandom_range(1, 19);
                default: f = $urandom();
            endcase
            go_silent();
            run_div(f, bc);
            chk($sformatf("rnd_hp_%0d", f), half_period, model_hp(f));
            chk($sformatf("rnd_busy_%0d", f), bc, (model_hp(f) != 0) ? 33 : 0);
        end

        // Start from silence at 20000 Hz: first edge after one half-period
        go_silent();
        run_div(32'd20000, bc);
        chk("seqA_spkr_at_load", spkr, 0);
        wait_toggle(cyc);
        chk("seqA_first_rise", cyc, 1250);
        chk("seqA_spkr_high", spkr, 1);
        wait_toggle(cyc);
        chk("seqA_second_edge", cyc, 1250);
        chk("seqA_active", active, 1);

        // Pitch change mid half-period is applied at the next edge
        repeat (100) tick();
        run_div(32'd10000, bc);
        chk("seqB_busy", bc, 33);
        chk("seqB_hp_held", half_period, 1250);
        wait_toggle(cyc);
        chk("seqB_old_spacing", cyc, 1250 - 134);
        chk("seqB_hp_new", half_period, 2500);
        wait_toggle(cyc);
        chk("seqB_new_spacing", cyc, 2500);

        // Mute and re-enable
        repeat (10) tick();
        play = 1'b0;
        tick();
        chk("seqC_spkr_muted", spkr, 0);
        tick();
        chk("seqC_active_muted", active, 0);
        repeat (50) tick();
        chk("seqC_spkr_still_muted", spkr, 0);
        chk("seqC_hp_held", half_period, 2500);
        play = 1'b1;
        wait_toggle(cyc);
        chk("seqC_restart_spacing", cyc, 2500);
        chk("seqC_spkr_rise", spkr, 1);

        // Changes during a division are ignored; the latest is picked up after
        go_silent();
        bc = 0;
        desiredFrequency = 32'd20000;
        for (int t = 0; t < 70; t++) begin
            if (t == 3) desiredFrequency = 32'd15000;
            if (t == 8) desiredFrequency = 32'd12000;
            tick();
            if (busy) bc++;
        end
        chk("seqD_busy_total", bc, 66);
        chk("seqD_hp_first", half_period, 1250);
        wait_toggle(cyc);
        chk("seqD_first_edge", cyc, 1250 - 36);
        chk("seqD_hp_final", half_period, 2083);
        wait_toggle(cyc);
        chk("seqD_final_spacing", cyc, 2083);

        // Out-of-range while running: silence on the next cycle, no division
        desiredFrequency = 32'd25000;
        tick();
        chk("seqE_hp_25000", half_period, 0);
        chk("seqE_spkr_25000", spkr, 0);
        bc = 0;
        repeat (40) begin
            tick();
            if (busy) bc++;
        end
        chk("seqE_busy_25000", bc, 0);
        chk("seqE_active", active, 0);
        desiredFrequency = 32'd10;
        bc = 0;
        repeat (40) begin
            tick();
            if (busy) bc++;
        end
        chk("seqE_busy_10", bc, 0);
        chk("seqE_hp_10", half_period, 0);

        // Reset mid-division aborts it; a fresh division follows
        go_silent();
        desiredFrequency = 32'd20000;
        repeat (15) tick();
        chk("seqF_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("seqF_busy_rst", busy, 0);
        chk("seqF_hp_rst", half_period, 0);
        chk("seqF_spkr_rst", spkr, 0);
        chk("seqF_active_rst", active, 0);
        repeat (2) tick();
        reset = 1'b0;
        run_div(32'd20000, bc);
        chk("seqF_busy_after", bc, 33);
        chk("seqF_hp_after", half_period, 1250);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
